// File: rtl/reg_read_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_read_scoreboard
// Purpose  : Decode-stage source tracking, load-use stall and forward selects.
// Revision : 1.0 - initial release
// ============================================================================
module reg_read_scoreboard (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic [4:0]  id_dest,
    input  logic        id_is_load,
    input  logic        flush,
    output logic        stall,
    output logic        rs_used,
    output logic        rt_used,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [4:0]  wb_dest
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_load;
    } stage_t;

    localparam stage_t     c_bubble     = '0;
    localparam logic [1:0] c_sel_rf     = 2'b00;
    localparam logic [1:0] c_sel_exmem  = 2'b01;
    localparam logic [1:0] c_sel_memwb  = 2'b10;
    localparam logic [1:0] c_sel_wb     = 2'b11;

    stage_t     r_ex, r_mem, r_wb;
    logic [1:0] r_fwd_a, r_fwd_b;

    logic [5:0] w_op, w_funct;
    logic [4:0] w_rs, w_rt;
    logic       w_rs_dec, w_rt_dec;
    logic       w_rs_used, w_rt_used;
    logic       w_stall;
    logic [1:0] w_sel_a, w_sel_b;
    logic       w_unused;

    assign w_op     = id_instr[31:26];
    assign w_rs     = id_instr[25:21];
    assign w_rt     = id_instr[20:16];
    assign w_funct  = id_instr[5:0];
    assign w_unused = ^id_instr[15:6];

    always_comb begin
        w_rs_dec = 1'b0;
        w_rt_dec = 1'b0;
        case (w_op)
            6'b000000: begin
                case (w_funct)
                    6'b000000, 6'b000010, 6'b000011: w_rt_dec = 1'b1;
                    6'b001000:                       w_rs_dec = 1'b1;
                    default: begin
                        w_rs_dec = 1'b1;
                        w_rt_dec = 1'b1;
                    end
                endcase
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110,
            6'b000001, 6'b000110, 6'b000111,
            6'b100000, 6'b100100, 6'b100011: w_rs_dec = 1'b1;
            6'b000100, 6'b000101, 6'b101000, 6'b101011: begin
                w_rs_dec = 1'b1;
                w_rt_dec = 1'b1;
            end
            default: begin
                w_rs_dec = 1'b0;
                w_rt_dec = 1'b0;
            end
        endcase
    end

    assign w_rs_used = id_valid & w_rs_dec;
    assign w_rt_used = id_valid & w_rt_dec;

    // Register $0 is never a real destination, so it can never hit.
    function automatic logic f_hit(input stage_t s, input logic [4:0] r);
        return s.valid && (r != 5'd0) && (s.dest == r);
    endfunction

    function automatic logic [1:0] f_sel(input logic used, input logic [4:0] r,
                                         input stage_t ex, input stage_t mem,
                                         input stage_t wb);
        if (!used)              return c_sel_rf;
        else if (f_hit(ex, r))  return c_sel_exmem;
        else if (f_hit(mem, r)) return c_sel_memwb;
        else if (f_hit(wb, r))  return c_sel_wb;
        else                    return c_sel_rf;
    endfunction

    assign w_sel_a = f_sel(w_rs_used, w_rs, r_ex, r_mem, r_wb);
    assign w_sel_b = f_sel(w_rt_used, w_rt, r_ex, r_mem, r_wb);

    // Only a load one stage ahead cannot be forwarded in time; flush overrides.
    assign w_stall = id_valid && !flush && r_ex.is_load &&
                     ((w_rs_used && f_hit(r_ex, w_rs)) ||
                      (w_rt_used && f_hit(r_ex, w_rt)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex    <= c_bubble;
            r_mem   <= c_bubble;
            r_wb    <= c_bubble;
            r_fwd_a <= c_sel_rf;
            r_fwd_b <= c_sel_rf;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_stall || flush || !id_valid) begin
                r_ex    <= c_bubble;
                r_fwd_a <= c_sel_rf;
                r_fwd_b <= c_sel_rf;
            end else begin
                r_ex.valid   <= 1'b1;
                r_ex.dest    <= id_dest;
                r_ex.is_load <= id_is_load;
                r_fwd_a      <= w_sel_a;
                r_fwd_b      <= w_sel_b;
            end
        end
    end

    assign stall   = w_stall;
    assign rs_used = w_rs_used;
    assign rt_used = w_rt_used;
    assign fwd_a   = r_fwd_a;
    assign fwd_b   = r_fwd_b;
    assign wb_dest = r_wb.valid ? r_wb.dest : 5'd0;

endmodule
`default_nettype wire

// File: doc/reg_read_scoreboard.md
REG_READ_SCOREBOARD -- requirements
Module: reg_read_scoreboard

Interface
REQ-001 The block SHALL have a single clock domain; reset is asynchronous and active-high.
REQ-002 clk  input  1  pipeline clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 id_instr  input  32  instruction currently in decode (ID).
REQ-005 id_valid  input  1  ID holds a real instruction.
REQ-006 id_dest  input  5  destination register of the ID instruction from the write-register decode (0 = no write).
REQ-007 id_is_load  input  1  ID instruction is LB/LBU/LW.
REQ-008 flush  input  1  squash the ID instruction (taken branch/jump).
REQ-009 stall  output  1  hold PC and IF/ID; insert bubble into EX (combinational).
REQ-010 rs_used, rt_used  output  1 each  ID instruction reads rs / rt (combinational).
REQ-011 fwd_a, fwd_b  output  2 each  registered operand-source selects for the instruction now in EX: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB write-through.
REQ-012 wb_dest  output  5  destination of the instruction in WB, 0 if bubble.

Function
REQ-013 Source decode (ISA.v encodings): SPECIAL (000000) SHALL read rs and rt, except funct 000000/000010/000011 (SLL/SRL/SRA): rt only; JR (funct 001000): rs only.
REQ-014 ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI, REGIMM, BLEZ, BGTZ, LB/LBU/LW SHALL read rs only.
REQ-015 BEQ, BNE, SB, SW SHALL read rs and rt; LUI, J, JAL and unrecognised opcodes SHALL read neither.
REQ-016 rs_used/rt_used SHALL be 0 when id_valid=0.
REQ-017 Tracking: three stage records EX, MEM, WB, each {valid, dest[4:0], is_load}; a record with dest=0 or valid=0 SHALL never match.
REQ-018 Match for a used source register r (r != 0): ex_hit = EX.valid & EX.dest==r; mem_hit, wb_hit likewise.
REQ-019 stall SHALL be 1 iff id_valid & !flush & (used rs or rt has ex_hit with EX.is_load=1).
REQ-020 Select per operand, priority EX > MEM > WB: ex_hit -> 01, else mem_hit -> 10, else wb_hit -> 11, else 00; unused operand -> 00.
REQ-021 Each rising edge: WB <= MEM; MEM <= EX.
REQ-022 EX <= {id_valid, id_dest, id_is_load} and fwd_a/fwd_b <= computed selects when stall=0 and flush=0.
REQ-023 When stall=1 or flush=1, EX SHALL load a bubble (valid=0, dest=0, is_load=0) and fwd_a/fwd_b <= 00.
REQ-024 flush and stall simultaneously: flush wins; stall output SHALL be 0.
REQ-025 A load in MEM matching an ID source SHALL NOT stall (select 10); a stalled load-use resolves after exactly one bubble cycle.
REQ-026 wb_dest SHALL equal WB.dest when WB.valid, else 0.

Reset
REQ-027 On reset assertion, all three records SHALL clear to bubbles immediately; fwd_a=fwd_b=00, wb_dest=0, stall=0 (given no valid ID).
REQ-028 Reset asserted mid-stall SHALL clear the stall condition the same cycle; no stale destinations survive reset.

Verification
REQ-029 ADDU $3,$1,$2 then ADDU $4,$3,$3 back-to-back -> at second instr in EX, fwd_a=fwd_b=01, stall never 1.
REQ-030 LW $5,0($1) then ADD $6,$5,$2 -> stall=1 for exactly one cycle, then instr enters EX with fwd_a=10, fwd_b=00.
REQ-031 Writes to $0 (e.g. ADDIU $0,$0,7) followed by reader of $0 -> fwd selects 00, no stall.
REQ-032 $7 written by both EX-stage and MEM-stage instrs, ID reads $7 -> select 01 (EX priority); instr three ahead only -> 11.
REQ-033 LW $8 in EX, ID BEQ $8,$9 with flush=1 same cycle -> stall=0, EX bubble, fwd 00.
REQ-034 Reset pulse during a load-use stall -> stall drops in same cycle, wb_dest=0, next reader of $5 gets select 00.
